// File: rtl/pulse_train_gen.sv
// pulse_train_gen: windowed pulse-train generator with guard band before each endcount strobe.
// Define PULSE_TRAIN_GEN_STAT_EN to build the per-window pulse count register (pulse_cnt).
module pulse_train_gen #(
  parameter int GUARD = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [15:0] npulse,
  input  logic [7:0]  high_w,
  input  logic [7:0]  low_w,
  output logic        pulse_out,
  output logic        endcount,
  output logic        busy,
  output logic [15:0] pulse_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;
  logic [1:0]  state, state_n;
  logic [31:0] offset, period_l, p_e, o_n;
  logic [15:0] npulse_l, cnt, np_e, cnt_e;
  logic [7:0]  hw_l, lw_l, ph, hw_r, hw_e, lw_e;
  logic [32:0] room;
  logic        last, start_win, dec, go_high;
  assign busy      = state != IDLE;
  assign last      = busy && offset == period_l - 32'd1;
  assign endcount  = last;
  assign pulse_out = state == HIGH;
  assign start_win = (!busy || last) && enable && period >= 32'(GUARD + 2);
  // At a window boundary the fresh inputs are used directly, as they are latched on that same edge
  assign p_e   = start_win ? period : period_l;
  assign np_e  = start_win ? npulse : npulse_l;
  assign hw_r  = start_win ? high_w : hw_l;
  assign hw_e  = hw_r == 8'd0 ? 8'd1 : hw_r;
  assign lw_e  = lw_l == 8'd0 ? 8'd1 : lw_l;
  assign o_n   = start_win ? 32'd0 : offset + 32'd1;
  assign cnt_e = start_win ? 16'd0 : cnt;
  assign room  = {1'b0, p_e} - {1'b0, o_n};
  assign dec     = start_win || (state == LOW && ph == 8'd0 && enable && !last);
  assign go_high = dec && cnt_e < np_e && room > 33'(hw_e) + 33'(GUARD);
  always_comb begin
    state_n = start_win ? (go_high ? HIGH : WAIT)
            : (!busy || last || !enable) ? IDLE
            : state == HIGH ? (ph == 8'd0 ? LOW : HIGH)
            : state == LOW  ? (ph == 8'd0 ? (go_high ? HIGH : WAIT) : LOW)
            : WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      offset   <= '0;
      period_l <= '0;
      npulse_l <= '0;
      hw_l     <= '0;
      lw_l     <= '0;
      cnt      <= '0;
      ph       <= '0;
    end else begin
      state  <= state_n;
      offset <= (start_win || state_n == IDLE) ? 32'd0 : offset + 32'd1;
      if (start_win) begin
        period_l <= period;
        npulse_l <= npulse;
        hw_l     <= high_w;
        lw_l     <= low_w;
      end
      cnt <= go_high ? cnt_e + 16'd1 : cnt_e;
      ph  <= go_high ? hw_e - 8'd1
           : (state == HIGH && ph == 8'd0) ? lw_e - 8'd1
           : ph != 8'd0 ? ph - 8'd1 : ph;
    end
  end
`ifdef PULSE_TRAIN_GEN_STAT_EN
  logic [15:0] stat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat <= '0;
    else if (last) stat <= cnt;
  end
  assign pulse_cnt = stat;
`else
  assign pulse_cnt = '0;
`endif
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: random and directed stimulus against a window-level reference model.
module tb_pulse_train_gen;
  localparam int G = 3;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        enable = 0;
  logic [31:0] period = 0;
  logic [15:0] npulse = 0;
  logic [7:0]  high_w = 0;
  logic [7:0]  low_w = 0;
  logic        pulse_out, endcount, busy;
  logic [15:0] pulse_cnt;
  int total = 0;
  int bad = 0;
  bit      m_run = 0;
  longint  m_off = 0, m_p = 0;
  int      m_h = 1, m_stat = 0;
  int      m_starts[$];
  pulse_train_gen #(.GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .npulse(npulse),
    .high_w(high_w), .low_w(low_w), .pulse_out(pulse_out), .endcount(endcount),
    .busy(busy), .pulse_cnt(pulse_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Window-level model: the pulse start offsets of each window are derived up front
  task automatic model_step();
    bit ec = m_run && m_off == m_p - 1;
    if (!m_run || ec) begin
      if (ec) m_stat = m_starts.size();
      if (enable && period >= G + 2) begin
        longint t = 0;
        int l = (low_w == 0) ? 1 : int'(low_w);
        m_run = 1;
        m_off = 0;
        m_p = period;
        m_h = (high_w == 0) ? 1 : int'(high_w);
        m_starts.delete();
        for (int k = 0; k < int'(npulse) && (m_p - t) > m_h + G; k++) begin
          m_starts.push_back(int'(t));
          t += m_h + l;
        end
      end else m_run = 0;
    end else if (!enable) m_run = 0;
    else m_off++;
  endtask
  task automatic compare();
    bit ep = 0;
    foreach (m_starts[i]) if (m_run && m_off >= m_starts[i] && m_off < m_starts[i] + m_h) ep = 1;
    check("pulse_out", pulse_out, ep);
    check("endcount", endcount, m_run && m_off == m_p - 1);
    check("busy", busy, m_run);
`ifdef PULSE_TRAIN_GEN_STAT_EN
    check("pulse_cnt", pulse_cnt, m_stat);
`else
    check("pulse_cnt", pulse_cnt, 0);
`endif
  endtask
  task automatic run(input int n, input bit en, input int p, input int np, input int hw, input int lw);
    for (int i = 0; i < n; i++) begin
      enable = en;
      period = p;
      npulse = 16'(np);
      high_w = 8'(hw);
      low_w  = 8'(lw);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask
  task automatic rnd(input int n);
    for (int i = 0; i < n; i++) begin
      enable = ($urandom_range(0, 49) != 0);
      period = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : $urandom_range(5, 40);
      npulse = 16'($urandom_range(0, 12));
      high_w = 8'($urandom_range(0, 5));
      low_w  = 8'($urandom_range(0, 5));
      model_step();
      @(negedge clk);
      compare();
    end
  endtask
  task automatic pulse_reset();
    #1 rst_n = 0;
    #1;
    check("rst_pulse_out", pulse_out, 0);
    check("rst_endcount", endcount, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse_cnt", pulse_cnt, 0);
    m_run = 0;
    m_off = 0;
    m_stat = 0;
    m_starts.delete();
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_pulse_out", pulse_out, 0);
    check("reset_endcount", endcount, 0);
    check("reset_pulse_cnt", pulse_cnt, 0);
    rst_n = 1;
    run(3, 0, 100, 5, 2, 3);
    run(230, 1, 100, 5, 2, 3);
    run(60, 1, 20, 10, 2, 2);
    run(40, 1, 10, 3, 0, 0);
    run(30, 1, 10, 0, 0, 0);
    run(10, 0, 50, 2, 3, 3);
    run(8, 1, 50, 2, 3, 3);
    run(5, 0, 50, 2, 3, 3);
    run(31, 1, 50, 4, 2, 2);
    pulse_reset();
    run(60, 1, 50, 4, 2, 2);
    run(20, 1, 4, 3, 1, 1);
    run(3, 0, 4, 3, 1, 1);
    rnd(3000);
    pulse_reset();
    rnd(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
